// File: rtl/alu_operand_sequencer.sv
// alu_operand_sequencer: issue/writeback stage around an external combinational 16-bit ALU.
// Commands are accepted one at a time and each takes three cycles: IDLE (handshake),
// EXEC (the ALU result is captured), and WB (writeback and flag update).
module alu_operand_sequencer #(
  parameter int NREGS  = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [2:0]        cmd_ra,
  input  logic [2:0]        cmd_rb,
  input  logic [2:0]        cmd_rd,
  input  logic              cmd_imm_en,
  input  logic [DATA_W-1:0] cmd_imm,
  output logic [DATA_W-1:0] alu_i0,
  output logic [DATA_W-1:0] alu_i1,
  output logic [1:0]        alu_op,
  input  logic [DATA_W-1:0] alu_o,
  input  logic              alu_carry,
  input  logic              alu_overflow,
  output logic              done_valid,
  output logic [2:0]        done_rd,
  output logic [DATA_W-1:0] done_data,
  output logic              flag_c,
  output logic              flag_v,
  output logic              flag_z,
  output logic              flag_n,
  input  logic [2:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0] regs [NREGS];
  logic [DATA_W-1:0] rd_a, rd_b;
  logic              handshake;
  logic              res_carry, res_overflow;

  // Operand reads. R0 is forced to zero here as well as never being written.
  always_comb begin
    rd_a = '0;
    rd_b = '0;
    dbg_data = '0;
    if (cmd_ra != 3'd0)   rd_a = regs[cmd_ra];
    if (cmd_rb != 3'd0)   rd_b = regs[cmd_rb];
    if (dbg_addr != 3'd0) dbg_data = regs[dbg_addr];
  end

  assign cmd_ready  = (state == IDLE);
  assign handshake  = cmd_valid && cmd_ready;
  assign done_valid = (state == WB);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode: a fixed three-step walk once a command is accepted.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (handshake) state_nxt = EXEC;
      EXEC:    state_nxt = WB;
      WB:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ALU operand/op registers change only on the handshake edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_i0  <= '0;
      alu_i1  <= '0;
      alu_op  <= '0;
      done_rd <= '0;
    end else if (handshake) begin
      alu_i0  <= rd_a;
      alu_i1  <= cmd_imm_en ? cmd_imm : rd_b;
      alu_op  <= cmd_op;
      done_rd <= cmd_rd;
    end
  end

  // Result capture one cycle after issue, while the ALU sees the registered operands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_data    <= '0;
      res_carry    <= 1'b0;
      res_overflow <= 1'b0;
    end else if (state == EXEC) begin
      done_data    <= alu_o;
      res_carry    <= alu_carry;
      res_overflow <= alu_overflow;
    end
  end

  // Writeback and flag update on the edge leaving WB; writes to R0 are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      flag_c <= 1'b0;
      flag_v <= 1'b0;
      flag_z <= 1'b0;
      flag_n <= 1'b0;
    end else if (state == WB) begin
      if (done_rd != 3'd0) regs[done_rd] <= done_data;
      flag_c <= res_carry;
      flag_v <= res_overflow;
      flag_z <= (done_data == '0);
      flag_n <= done_data[DATA_W-1];
    end
  end

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// tb_alu_operand_sequencer: randomized and directed checks of the sequencer against
// a register-file/flag model; the bench also plays the part of the external ALU.
module tb_alu_operand_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [2:0]  cmd_ra, cmd_rb, cmd_rd;
  logic        cmd_imm_en;
  logic [15:0] cmd_imm;
  logic [15:0] alu_i0, alu_i1;
  logic [1:0]  alu_op;
  logic [15:0] alu_o;
  logic        alu_carry, alu_overflow;
  logic        done_valid;
  logic [2:0]  done_rd;
  logic [15:0] done_data;
  logic        flag_c, flag_v, flag_z, flag_n;
  logic [2:0]  dbg_addr;
  logic [15:0] dbg_data;

  int vectors = 0;
  int miscompares = 0;

  // Reference state.
  logic [15:0] ref_regs [8];
  logic        ref_c, ref_v, ref_z, ref_n;

  alu_operand_sequencer #(.NREGS(8), .DATA_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_ra(cmd_ra), .cmd_rb(cmd_rb), .cmd_rd(cmd_rd),
    .cmd_imm_en(cmd_imm_en), .cmd_imm(cmd_imm),
    .alu_i0(alu_i0), .alu_i1(alu_i1), .alu_op(alu_op),
    .alu_o(alu_o), .alu_carry(alu_carry), .alu_overflow(alu_overflow),
    .done_valid(done_valid), .done_rd(done_rd), .done_data(done_data),
    .flag_c(flag_c), .flag_v(flag_v), .flag_z(flag_z), .flag_n(flag_n),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  // Arithmetic meaning of each op, returned as {overflow, carry, result}.
  function automatic logic [17:0] aluModel(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    logic [15:0] r;
    logic        c, v;
    c = 1'b0;
    v = 1'b0;
    case (op)
      2'b00: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[15:0];
        c = s[16];
        v = (a[15] == b[15]) && (r[15] != a[15]);
      end
      2'b01: begin
        r = a - b;
        c = (a < b);
        v = (a[15] != b[15]) && (r[15] != a[15]);
      end
      2'b10:   r = a & b;
      default: r = a | b;
    endcase
    return {v, c, r};
  endfunction

  // The external combinational ALU.
  always_comb {alu_overflow, alu_carry, alu_o} = aluModel(alu_op, alu_i0, alu_i1);

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic resetModel();
    for (int i = 0; i < 8; i++) ref_regs[i] = 16'h0000;
    {ref_c, ref_v, ref_z, ref_n} = 4'b0000;
  endtask

  task automatic checkFlags(input string tag);
    checkOutput({tag, "_c"}, flag_c, ref_c);
    checkOutput({tag, "_v"}, flag_v, ref_v);
    checkOutput({tag, "_z"}, flag_z, ref_z);
    checkOutput({tag, "_n"}, flag_n, ref_n);
  endtask

  // Issue one command, verify each of its three cycles, and update the model.
  task automatic applyStimulus(input logic [1:0] op, input logic [2:0] ra, input logic [2:0] rb,
                               input logic [2:0] rd, input logic imm_en, input logic [15:0] imm);
    logic [15:0] a, b, old_rd;
    logic [17:0] res;
    int wait_cycles;
    @(negedge clk);
    wait_cycles = 0;
    while (!cmd_ready && wait_cycles < 10) begin
      @(negedge clk);
      wait_cycles++;
    end
    checkOutput("ready_before_issue", cmd_ready, 1'b1);
    a   = (ra == 3'd0) ? 16'h0000 : ref_regs[ra];
    b   = imm_en ? imm : ((rb == 3'd0) ? 16'h0000 : ref_regs[rb]);
    res = aluModel(op, a, b);
    old_rd = ref_regs[rd];
    cmd_op = op; cmd_ra = ra; cmd_rb = rb; cmd_rd = rd; cmd_imm_en = imm_en; cmd_imm = imm;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    // Fields scrambled after the handshake must have no effect.
    cmd_valid = 1'b0;
    cmd_op = 2'($urandom); cmd_ra = 3'($urandom); cmd_rb = 3'($urandom);
    cmd_rd = 3'($urandom); cmd_imm_en = 1'($urandom); cmd_imm = 16'($urandom);
    checkOutput("exec_ready", cmd_ready, 1'b0);
    checkOutput("exec_done_valid", done_valid, 1'b0);
    checkOutput("exec_alu_i0", alu_i0, a);
    checkOutput("exec_alu_i1", alu_i1, b);
    checkOutput("exec_alu_op", alu_op, op);
    @(posedge clk); #1;
    dbg_addr = rd; #1;
    checkOutput("wb_done_valid", done_valid, 1'b1);
    checkOutput("wb_ready", cmd_ready, 1'b0);
    checkOutput("wb_done_rd", done_rd, rd);
    checkOutput("wb_done_data", done_data, res[15:0]);
    checkOutput("wb_dbg_old", dbg_data, old_rd);
    if (rd != 3'd0) ref_regs[rd] = res[15:0];
    ref_c = res[16];
    ref_v = res[17];
    ref_z = (res[15:0] == 16'h0000);
    ref_n = res[15];
    @(posedge clk); #1;
    checkOutput("post_done_valid", done_valid, 1'b0);
    checkOutput("post_ready", cmd_ready, 1'b1);
    checkOutput("post_dbg_new", dbg_data, ref_regs[rd]);
    checkOutput("post_alu_i0_held", alu_i0, a);
    checkFlags("post_flag");
  endtask

  task automatic loadImm(input logic [2:0] rd, input logic [15:0] imm);
    applyStimulus(2'b11, 3'd0, 3'd0, rd, 1'b1, imm);
  endtask

  initial begin
    int hs_count;
    int hs_cycle [$];
    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_op = 2'b00; cmd_ra = 3'd0; cmd_rb = 3'd0; cmd_rd = 3'd0;
    cmd_imm_en = 1'b0; cmd_imm = 16'h0000; dbg_addr = 3'd0;
    resetModel();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state.
    checkOutput("rst_ready", cmd_ready, 1'b1);
    checkOutput("rst_done_valid", done_valid, 1'b0);
    checkOutput("rst_done_rd", done_rd, 3'd0);
    checkOutput("rst_done_data", done_data, 16'h0000);
    checkFlags("rst_flag");
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i); #1;
      checkOutput("rst_dbg", dbg_data, 16'h0000);
    end

    // Immediate load.
    loadImm(3'd1, 16'h1234);
    checkOutput("imm_r1", ref_regs[1] == 16'h1234 ? dbg_data : 16'hDEAD, 16'h1234);

    // Signed overflow on add.
    loadImm(3'd1, 16'h7FFF);
    loadImm(3'd2, 16'h0001);
    applyStimulus(2'b00, 3'd1, 3'd2, 3'd3, 1'b0, 16'h0000);
    checkOutput("add_ovf_r3", done_data, 16'h8000);
    checkOutput("add_ovf_v", flag_v, 1'b1);
    checkOutput("add_ovf_n", flag_n, 1'b1);

    // Carry out and zero on add with immediate.
    loadImm(3'd1, 16'hFFFF);
    applyStimulus(2'b00, 3'd1, 3'd0, 3'd4, 1'b1, 16'h0001);
    checkOutput("add_carry_c", flag_c, 1'b1);
    checkOutput("add_carry_z", flag_z, 1'b1);

    // Borrow and signed overflow on sub.
    loadImm(3'd5, 16'h0001);
    loadImm(3'd6, 16'h0002);
    applyStimulus(2'b01, 3'd5, 3'd6, 3'd7, 1'b0, 16'h0000);
    checkOutput("sub_borrow_data", done_data, 16'hFFFF);
    checkOutput("sub_borrow_c", flag_c, 1'b1);
    loadImm(3'd5, 16'h8000);
    applyStimulus(2'b01, 3'd5, 3'd0, 3'd7, 1'b1, 16'h0001);
    checkOutput("sub_ovf_data", done_data, 16'h7FFF);
    checkOutput("sub_ovf_v", flag_v, 1'b1);

    // Logic op.
    loadImm(3'd1, 16'hF0F0);
    loadImm(3'd2, 16'h0FF0);
    applyStimulus(2'b10, 3'd1, 3'd2, 3'd3, 1'b0, 16'h0000);
    checkOutput("and_data", done_data, 16'h00F0);

    // Write to R0 is discarded but still sets flags.
    loadImm(3'd0, 16'hFFFF);
    checkOutput("r0_n", flag_n, 1'b1);
    dbg_addr = 3'd0; #1;
    checkOutput("r0_dbg", dbg_data, 16'h0000);

    // Randomized commands.
    for (int i = 1; i < 8; i++) loadImm(3'(i), 16'($urandom));
    for (int k = 0; k < 60; k++)
      applyStimulus(2'($urandom), 3'($urandom), 3'($urandom), 3'($urandom),
                    1'($urandom_range(0, 3) == 0), 16'($urandom));

    // Backpressure: cmd_valid held high, handshakes every third edge.
    @(negedge clk);
    hs_count = 0;
    cmd_op = 2'b11; cmd_ra = 3'd0; cmd_rb = 3'd0; cmd_rd = 3'd4; cmd_imm_en = 1'b1; cmd_imm = 16'h0055;
    cmd_valid = 1'b1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (cmd_valid && cmd_ready) begin
        hs_count++;
        hs_cycle.push_back(cyc);
      end
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    checkOutput("bp_count", hs_count, 4);
    for (int i = 1; i < hs_cycle.size(); i++)
      checkOutput("bp_spacing", hs_cycle[i] - hs_cycle[i-1], 3);
    ref_regs[4] = 16'h0055;
    {ref_c, ref_v, ref_z, ref_n} = 4'b0000;
    dbg_addr = 3'd4; #1;
    checkOutput("bp_r4", dbg_data, 16'h0055);
    checkFlags("bp_flag");

    // Reset during EXEC: the in-flight command must vanish.
    loadImm(3'd1, 16'h8001);
    @(negedge clk);
    cmd_op = 2'b00; cmd_ra = 3'd1; cmd_rb = 3'd1; cmd_rd = 3'd2; cmd_imm_en = 1'b0;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    checkOutput("midrst_in_exec", cmd_ready, 1'b0);
    rst_n = 1'b0;
    resetModel();
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      checkOutput("midrst_no_done", done_valid, 1'b0);
    end
    dbg_addr = 3'd2; #1;
    checkOutput("midrst_r2", dbg_data, 16'h0000);
    checkOutput("midrst_ready", cmd_ready, 1'b1);
    checkFlags("midrst_flag");

    // One command after the mid-op reset to confirm normal operation resumes.
    applyStimulus(2'b00, 3'd1, 3'd0, 3'd3, 1'b1, 16'h0007);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Watchdog.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/alu_operand_sequencer.md
# alu_operand_sequencer

- Sequential issue/writeback stage wrapped around the 16-bit ALU.
- Accepts register-based commands over a valid/ready handshake and reads operands from an internal 8×16 register file.
- Drives the ALU's `i0`/`i1`/`op` from registers, captures `o`/`carry`/`overflow` one cycle later, then writes the result back and updates the condition flags.
- Sits directly upstream (operand feed) and downstream (result capture) of the ALU; the ALU itself stays combinational and external.

## Interface

Parameters:
- `NREGS`, 8: register-file depth. Fixed at 8; register index is 3 bits.
- `DATA_W`, 16: datapath width. Must match the ALU.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  block can accept a command.
- `cmd_op`  in  2  00 add, 01 sub, 10 and, 11 or.
- `cmd_ra`  in  3  source A register index.
- `cmd_rb`  in  3  source B register index.
- `cmd_rd`  in  3  destination register index.
- `cmd_imm_en`  in  1  1: operand B comes from `cmd_imm` instead of `cmd_rb`.
- `cmd_imm`  in  16  immediate operand.
- `alu_i0`  out  16  registered operand A to the ALU.
- `alu_i1`  out  16  registered operand B to the ALU.
- `alu_op`  out  2  registered op code to the ALU.
- `alu_o`  in  16  ALU result.
- `alu_carry`  in  1  ALU carry out.
- `alu_overflow`  in  1  ALU signed overflow.
- `done_valid`  out  1  one-cycle pulse, command retired.
- `done_rd`  out  3  destination index of the retired command.
- `done_data`  out  16  result of the retired command.
- `flag_c`, `flag_v`, `flag_z`, `flag_n`  out  1 each  condition flags.
- `dbg_addr`  in  3  debug read index.
- `dbg_data`  out  16  combinational register-file read.

## Operation

- **FSM:** IDLE → EXEC → WB → IDLE. No other states. `cmd_ready` = (state == IDLE), decoded combinationally from state only.
- **IDLE:**
  - Handshake occurs when `cmd_valid && cmd_ready`. On that edge, register the operands: `alu_i0` ← R[ra], `alu_i1` ← (`cmd_imm_en` ? `cmd_imm` : R[rb]), `alu_op` ← `cmd_op`, latch `rd`; go to EXEC.
  - Without a handshake, remain in IDLE with all outputs held.
- **EXEC:** capture `alu_o`, `alu_carry` and `alu_overflow` into result registers; go to WB.
- **WB:**
  - Assert `done_valid`, with `done_rd`/`done_data` showing the captured values.
  - On the exiting edge:
    - write R[rd] ← result, unless rd == 0;
    - `flag_c` ← captured carry;
    - `flag_v` ← captured overflow;
    - `flag_z` ← (result == 0);
    - `flag_n` ← result[15].
  - Go to IDLE.
- **R0:** hardwired to zero. Reads as 0 on operand reads and on `dbg_data`; writes to R0 are discarded. `done_data` and the flags still reflect the computed result.
- **Immediate loads:** loading an immediate is `or` with ra = 0 and `cmd_imm_en` = 1.
- **Flags:**
  - Updated on every retired command, including and/or (for which the ALU reports carry and overflow as 0).
  - `flag_c` takes `alu_carry` unmodified; for sub it is the borrow bit.
- **Commands are serial:** no read-after-write hazard is possible. Command fields are ignored unless a handshake occurs.
- **Reset** (asynchronous assert, release on a clock edge):
  - state = IDLE; all R[n] = 0;
  - `alu_i0`, `alu_i1`, `alu_op`, `done_rd`, `done_data` and the result registers = 0;
  - `done_valid` = 0; all flags = 0; `cmd_ready` = 1 once `rst_n` is high.
  - A command in flight is discarded: no register write, no flag update, no `done_valid` pulse.

## Timing

- Handshake on the edge ending cycle T.
- Cycle T+1: EXEC, with `alu_*` outputs valid.
- Cycle T+2: WB, with `done_valid` = 1.
- Register-file and flag updates are visible from T+3, which is also when `cmd_ready` returns to 1.
- Throughput: one command per 3 cycles. `cmd_ready` is 0 during T+1 and T+2.
- `dbg_data` is combinational from the current register-file contents. During WB it shows the old R[rd].
- `alu_i0`/`alu_i1`/`alu_op` hold their last values outside EXEC. They change only on a handshake edge or a reset.

## Test plan

- **Reset:** hold `rst_n` = 0, then release → `cmd_ready` = 1, all flags and `done_*` = 0, and `dbg_data` = 0x0000 for every `dbg_addr` 0–7.
- **Immediate load:** `or` ra = 0, imm_en = 1, imm = 0x1234, rd = 1 at T → `done_valid` only at T+2 with `done_rd` = 1, `done_data` = 0x1234; from T+3, Z = 0, N = 0, C = 0, V = 0 and dbg R1 = 0x1234.
- **Add:**
  - R1 = 0x7FFF, R2 = 0x0001, `add` rd = 3 → R3 = 0x8000, V = 1, N = 1, C = 0, Z = 0.
  - R1 = 0xFFFF plus imm 0x0001 → result 0x0000, C = 1, Z = 1, V = 0.
- **Sub and logic:**
  - 0x0001 − 0x0002 → 0xFFFF, C = 1, N = 1, V = 0.
  - 0x8000 − 0x0001 → 0x7FFF, V = 1.
  - `and` 0xF0F0 with 0x0FF0 → 0x00F0, C = 0, V = 0.
- **R0 write:** `or` ra = 0, imm = 0xFFFF, rd = 0 → `done_data` = 0xFFFF, N = 1, and dbg R0 still reads 0x0000.
- **Backpressure and mid-op reset:**
  - Hold `cmd_valid` = 1 continuously → handshakes occur exactly every 3 cycles.
  - Pulse `rst_n` low during EXEC → no `done_valid` pulse, destination register remains 0, all flags 0.
